// File: rtl/key_debounce_pulse.sv
// Two-key pushbutton debouncer: per-key synchronizer and debounce FSM, producing
// one-cycle press pulses (step/load) and debounced key levels.
module key_debounce_pulse #(
  parameter int CNT_W           = 20,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] key_n,
  output logic       step_pulse,
  output logic       load_pulse,
  output logic [1:0] key_level
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       w_dn;
  state_t           r_state     [2];
  state_t           w_state_nxt [2];
  logic [CNT_W-1:0] r_cnt       [2];
  logic [CNT_W-1:0] w_cnt_nxt   [2];
  logic [1:0]       w_press;
  logic [1:0]       w_level_nxt;
  logic             r_step;
  logic             r_load;
  logic [1:0]       r_level;

  // Synchronizer stage; released (1) is the safe reset value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= key_n;
      r_sync2 <= r_sync1;
    end
  end

  assign w_dn = ~r_sync2;

  // Debounce FSM stage: counter only advances while it is below LAST, so it never wraps
  always_comb begin
    w_press     = 2'b00;
    w_level_nxt = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];
      case (r_state[i])
        IDLE: begin
          if (w_dn[i]) begin
            w_state_nxt[i] = PRESS_WAIT;
            w_cnt_nxt[i]   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!w_dn[i]) begin
            w_state_nxt[i] = IDLE;
          end else if (r_cnt[i] == LAST) begin
            w_state_nxt[i] = HELD;
            w_press[i]     = 1'b1;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        HELD: begin
          if (!w_dn[i]) begin
            w_state_nxt[i] = RELEASE_WAIT;
            w_cnt_nxt[i]   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (w_dn[i]) begin
            w_state_nxt[i] = HELD;
          end else if (r_cnt[i] == LAST) begin
            w_state_nxt[i] = IDLE;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt[i] = IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase
      w_level_nxt[i] = (w_state_nxt[i] == HELD) || (w_state_nxt[i] == RELEASE_WAIT);
    end
  end

  // Output stage: a simultaneous press favours load, the step press is dropped
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= IDLE;
        r_cnt[i]   <= '0;
      end
      r_step  <= 1'b0;
      r_load  <= 1'b0;
      r_level <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_step  <= w_press[0] & ~w_press[1];
      r_load  <= w_press[1];
      r_level <= w_level_nxt;
    end
  end

  assign step_pulse = r_step;
  assign load_pulse = r_load;
  assign key_level  = r_level;

endmodule
